// File: rtl/alu_sequencer.sv
// alu_sequencer: fetch/decode/execute/writeback controller for a 4-bit ALU.
// Each instruction is an 8-bit word {opcode, imm} read from a synchronous ROM
// and takes exactly four cycles. The ALU is external and registers its result
// at the end of the EXEC cycle; the sequencer consumes it during WB.
module alu_sequencer #(
    parameter int                ADDR_W   = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              RUN,
    output logic [ADDR_W-1:0] ROM_ADDR,
    output logic              ROM_EN,
    input  logic [7:0]        ROM_DATA,
    output logic [3:0]        ALU_INST,
    output logic [3:0]        ALU_IN1,
    output logic [3:0]        ALU_IN2,
    input  logic [3:0]        ALU_OUT,
    input  logic              ALU_C,
    output logic [3:0]        REG_A,
    output logic [3:0]        REG_B,
    output logic [3:0]        OUT_PORT,
    output logic              CARRY,
    output logic              BUSY
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_WB     = 2'd3
    } state_t;

    localparam logic [3:0] OP_JNC = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_LDB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'h3;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        ir_q, ir_d;
    logic [3:0]        a_q, a_d;
    logic [3:0]        b_q, b_d;
    logic [3:0]        out_q, out_d;
    logic              carry_q, carry_d;
    logic [3:0]        inst_q, inst_d;
    logic [3:0]        in1_q, in1_d;
    logic [3:0]        in2_q, in2_d;
    logic              busy_q, busy_d;

    logic [3:0]        op;
    logic [ADDR_W-1:0] imm_ext;
    logic [ADDR_W-1:0] pc_inc;

    assign op      = ir_q[7:4];
    assign imm_ext = ADDR_W'(ir_q[3:0]);
    assign pc_inc  = pc_q + ADDR_W'(1);

    // Next-state and next-output logic for the four-phase instruction cycle.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        out_d   = out_q;
        carry_d = carry_q;
        // ALU controls default to zero so the ALU holds in every non-EXEC cycle
        inst_d  = '0;
        in1_d   = '0;
        in2_d   = '0;
        unique case (state_q)
            S_FETCH: begin
                if (RUN) state_d = S_DECODE;
            end
            S_DECODE: begin
                // ROM word is valid now; ALU operands are set up from it so
                // they appear registered for the whole EXEC cycle.
                ir_d    = ROM_DATA;
                state_d = S_EXEC;
                inst_d  = ROM_DATA[7:4];
                case (ROM_DATA[7:4])
                    OP_JNC: ;
                    OP_LDA, OP_LDB: in1_d = ROM_DATA[3:0];
                    OP_OUT: in1_d = a_q;
                    default: begin
                        in1_d = a_q;
                        in2_d = ROM_DATA[4] ? b_q : ROM_DATA[3:0];
                    end
                endcase
            end
            S_EXEC: begin
                state_d = S_WB;
            end
            S_WB: begin
                state_d = S_FETCH;
                if (op == OP_JNC) begin
                    pc_d = carry_q ? pc_inc : imm_ext;
                end else begin
                    pc_d    = pc_inc;
                    carry_d = ALU_C;
                    case (op)
                        OP_LDA:  a_d   = ALU_OUT;
                        OP_LDB:  b_d   = ALU_OUT;
                        OP_OUT:  out_d = ALU_OUT;
                        default: a_d   = ALU_OUT;
                    endcase
                end
            end
        endcase
        busy_d = (state_d != S_FETCH);
    end

    // State, architectural registers and registered ALU/status outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            out_q   <= '0;
            carry_q <= 1'b0;
            inst_q  <= '0;
            in1_q   <= '0;
            in2_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            out_q   <= out_d;
            carry_q <= carry_d;
            inst_q  <= inst_d;
            in1_q   <= in1_d;
            in2_q   <= in2_d;
            busy_q  <= busy_d;
        end
    end

    // ROM strobe follows RUN directly so the first fetch after reset release
    // is issued without a dead cycle; forced low while reset is asserted.
    assign ROM_EN   = RST_N && (state_q == S_FETCH) && RUN;
    assign ROM_ADDR = pc_q;
    assign ALU_INST = inst_q;
    assign ALU_IN1  = in1_q;
    assign ALU_IN2  = in2_q;
    assign REG_A    = a_q;
    assign REG_B    = b_q;
    assign OUT_PORT = out_q;
    assign CARRY    = carry_q;
    assign BUSY     = busy_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: ROM and registered ALU models as environment, an
// instruction-level reference model compared every cycle, plus literal checks.
module tb_alu_sequencer;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       RUN = 1'b0;
    logic [3:0] ROM_ADDR;
    logic       ROM_EN;
    logic [7:0] rom_data = 8'h00;
    logic [3:0] ALU_INST, ALU_IN1, ALU_IN2;
    logic [3:0] alu_out = 4'h0;
    logic       alu_c = 1'b0;
    logic [3:0] REG_A, REG_B, OUT_PORT;
    logic       CARRY, BUSY;

    logic [7:0] rom [16];

    int tests = 0;
    int fails = 0;

    alu_sequencer #(.ADDR_W(4), .RESET_PC(4'h0)) dut (
        .CLK(CLK), .RST_N(RST_N), .RUN(RUN),
        .ROM_ADDR(ROM_ADDR), .ROM_EN(ROM_EN), .ROM_DATA(rom_data),
        .ALU_INST(ALU_INST), .ALU_IN1(ALU_IN1), .ALU_IN2(ALU_IN2),
        .ALU_OUT(alu_out), .ALU_C(alu_c),
        .REG_A(REG_A), .REG_B(REG_B), .OUT_PORT(OUT_PORT),
        .CARRY(CARRY), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    // ALU function: {carry, result}
    function automatic logic [4:0] alu5(input logic [3:0] inst, input logic [3:0] a,
                                        input logic [3:0] x);
        case (inst)
            4'd1, 4'd2, 4'd3:  return {1'b0, a};
            4'd4, 4'd5:        return {1'b0, a} + {1'b0, x};
            4'd6, 4'd7:        return {1'b0, a} - {1'b0, x};
            4'd8, 4'd9:        return {1'b0, a & x};
            4'd10, 4'd11:      return {1'b0, a | x};
            4'd12, 4'd13:      return {1'b0, ~(a & x)};
            4'd14, 4'd15:      return {1'b0, a ^ x};
            default:           return 5'd0;
        endcase
    endfunction

    // synchronous ROM
    always @(posedge CLK)
        if (ROM_EN) rom_data <= rom[ROM_ADDR];

    // registered ALU, holds while INST == 0
    always @(posedge CLK)
        if (ALU_INST != 4'h0) {alu_c, alu_out} <= alu5(ALU_INST, ALU_IN1, ALU_IN2);

    // reference model: instruction retires as a whole on its fourth clock
    int         m_phase;
    logic [3:0] m_pc, m_a, m_b, m_out;
    logic       m_c;
    logic [7:0] m_ir;
    logic [3:0] m_op, m_imm;
    assign m_op  = m_ir[7:4];
    assign m_imm = m_ir[3:0];

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_phase <= 0; m_pc <= 4'h0; m_a <= 4'h0; m_b <= 4'h0;
            m_out <= 4'h0; m_c <= 1'b0; m_ir <= 8'h00;
        end else begin
            case (m_phase)
                0: if (RUN) begin m_ir <= rom[m_pc]; m_phase <= 1; end
                1: m_phase <= 2;
                2: m_phase <= 3;
                default: begin
                    m_phase <= 0;
                    case (m_op)
                        4'h0: m_pc <= m_c ? m_pc + 4'h1 : m_imm;
                        4'h1: begin m_a <= m_imm; m_c <= 1'b0; m_pc <= m_pc + 4'h1; end
                        4'h2: begin m_b <= m_imm; m_c <= 1'b0; m_pc <= m_pc + 4'h1; end
                        4'h3: begin m_out <= m_a; m_c <= 1'b0; m_pc <= m_pc + 4'h1; end
                        default: begin
                            {m_c, m_a} <= alu5(m_op, m_a, m_op[0] ? m_b : m_imm);
                            m_pc <= m_pc + 4'h1;
                        end
                    endcase
                end
            endcase
        end
    end

    // expected ALU drive: only during the execute cycle
    logic [3:0] e_inst, e_in1, e_in2;
    always_comb begin
        e_inst = 4'h0; e_in1 = 4'h0; e_in2 = 4'h0;
        if (m_phase == 2) begin
            e_inst = m_op;
            case (m_op)
                4'h0: ;
                4'h1, 4'h2: e_in1 = m_imm;
                4'h3: e_in1 = m_a;
                default: begin e_in1 = m_a; e_in2 = m_op[0] ? m_b : m_imm; end
            endcase
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // per-cycle comparison against the model
    always @(negedge CLK) begin
        chk("rom_addr", 8'(ROM_ADDR), 8'(m_pc));
        chk("rom_en",   8'(ROM_EN),   8'(RST_N && RUN && m_phase == 0));
        chk("busy",     8'(BUSY),     8'(m_phase != 0));
        chk("alu_inst", 8'(ALU_INST), 8'(e_inst));
        chk("alu_in1",  8'(ALU_IN1),  8'(e_in1));
        chk("alu_in2",  8'(ALU_IN2),  8'(e_in2));
        chk("reg_a",    8'(REG_A),    8'(m_a));
        chk("reg_b",    8'(REG_B),    8'(m_b));
        chk("out_port", 8'(OUT_PORT), 8'(m_out));
        chk("carry",    8'(CARRY),    8'(m_c));
    end

    task automatic hold_reset();
        @(negedge CLK); #2;
        RST_N = 1'b0; RUN = 1'b0;
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    endtask

    task automatic release_run();
        @(negedge CLK); #2;
        RST_N = 1'b1; RUN = 1'b1;
    endtask

    task automatic edges(input int n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
        edges(2);
        chk("rst_addr", 8'(ROM_ADDR), 8'h0);
        chk("rst_busy", 8'(BUSY), 8'h0);
        chk("rst_a", 8'(REG_A), 8'h0);

        // LDA 2; ADD 3
        rom[0] = 8'h12; rom[1] = 8'h43;
        release_run();
        #1;
        chk("first_addr", 8'(ROM_ADDR), 8'h0);
        chk("first_en", 8'(ROM_EN), 8'h1);
        edges(6);
        chk("add_inst", 8'(ALU_INST), 8'h4);
        chk("add_in1", 8'(ALU_IN1), 8'h2);
        chk("add_in2", 8'(ALU_IN2), 8'h3);
        edges(2);
        chk("add_a", 8'(REG_A), 8'h5);
        chk("add_c", 8'(CARRY), 8'h0);

        // reset asserted during ADD's execute cycle
        hold_reset();
        rom[0] = 8'h12; rom[1] = 8'h43;
        release_run();
        edges(6); #2;
        RST_N = 1'b0;
        #1;
        chk("mid_rst_inst", 8'(ALU_INST), 8'h0);
        chk("mid_rst_in1", 8'(ALU_IN1), 8'h0);
        chk("mid_rst_a", 8'(REG_A), 8'h0);
        chk("mid_rst_busy", 8'(BUSY), 8'h0);
        chk("mid_rst_en", 8'(ROM_EN), 8'h0);
        chk("mid_rst_pc", 8'(ROM_ADDR), 8'h0);
        release_run();
        #1;
        chk("rel_addr", 8'(ROM_ADDR), 8'h0);
        chk("rel_en", 8'(ROM_EN), 8'h1);
        edges(8);
        chk("rel_a", 8'(REG_A), 8'h5);

        // LDA 9; ADD 8; JNC 0; LDA 0; JNC 0
        hold_reset();
        rom[0] = 8'h19; rom[1] = 8'h48; rom[2] = 8'h00; rom[3] = 8'h10; rom[4] = 8'h00;
        release_run();
        edges(8);
        chk("ovf_a", 8'(REG_A), 8'h1);
        chk("ovf_c", 8'(CARRY), 8'h1);
        edges(4);
        chk("jnc_nt_pc", 8'(ROM_ADDR), 8'h3);
        edges(4);
        chk("lda0_c", 8'(CARRY), 8'h0);
        edges(4);
        chk("jnc_t_pc", 8'(ROM_ADDR), 8'h0);

        // LDB 6; LDA C; SUB B; XOR F
        hold_reset();
        rom[0] = 8'h26; rom[1] = 8'h1C; rom[2] = 8'h70; rom[3] = 8'hEF;
        release_run();
        edges(10);
        chk("sub_inst", 8'(ALU_INST), 8'h7);
        chk("sub_in2", 8'(ALU_IN2), 8'h6);
        edges(2);
        chk("sub_a", 8'(REG_A), 8'h6);
        chk("sub_c", 8'(CARRY), 8'h0);
        edges(4);
        chk("xor_a", 8'(REG_A), 8'h9);

        // LDA 7; OUT with RUN dropped during OUT's decode
        hold_reset();
        rom[0] = 8'h17; rom[1] = 8'h30;
        release_run();
        edges(5); #2;
        RUN = 1'b0;
        edges(3);
        chk("out_port", 8'(OUT_PORT), 8'h7);
        chk("out_a", 8'(REG_A), 8'h7);
        chk("halt_busy", 8'(BUSY), 8'h0);
        chk("halt_pc", 8'(ROM_ADDR), 8'h2);
        edges(4);
        chk("halt_pc2", 8'(ROM_ADDR), 8'h2);
        chk("halt_en", 8'(ROM_EN), 8'h0);

        // PC wrap: sixteen LDA instructions
        hold_reset();
        for (int i = 0; i < 16; i++) rom[i] = 8'h10 | 8'(i);
        release_run();
        edges(60);
        chk("wrap_pc15", 8'(ROM_ADDR), 8'hF);
        chk("wrap_a14", 8'(REG_A), 8'hE);
        edges(4);
        chk("wrap_pc0", 8'(ROM_ADDR), 8'h0);
        chk("wrap_a15", 8'(REG_A), 8'hF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
